// File: rtl/atm_account_engine_if.sv
// Command/result bundle for the ATM account engine.
// The master drives the command fields; the engine (slave) returns lookup flags and results.
interface atm_account_engine_if;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [31:0] amount;
    logic [2:0]  operation;
    logic        op_valid;
    logic [3:0]  acc_index;
    logic        acc_found;
    logic        acc_auth;
    logic [31:0] balance;
    logic        success;
    logic        done;

    modport master (
        output acc_num, pin, newPin, amount, operation, op_valid,
        input  acc_index, acc_found, acc_auth, balance, success, done
    );

    modport slave (
        input  acc_num, pin, newPin, amount, operation, op_valid,
        output acc_index, acc_found, acc_auth, balance, success, done
    );
endinterface

// File: rtl/atm_account_engine.sv
// ATM account datapath: PIN/balance tables, combinational lookup, one-cycle command execution.
// Optional ATM_LOCKOUT_EN adds per-account failure counters and a lock after three bad PINs.
module atm_account_engine #(
    parameter int          NUM_ACCOUNTS  = 10,
    parameter logic [15:0] PIN_INIT_BASE = 16'd1000,
    parameter logic [31:0] BAL_INIT      = 32'd1000
) (
    input logic                 clk,
    input logic                 rst,
    atm_account_engine_if.slave bus
);
    localparam logic [2:0] OP_BALANCE    = 3'd3;
    localparam logic [2:0] OP_WITHDRAW   = 3'd4;
    localparam logic [2:0] OP_DEPOSIT    = 3'd5;
    localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

    logic [15:0] pin_tab [NUM_ACCOUNTS];
    logic [31:0] bal_tab [NUM_ACCOUNTS];

    logic [3:0]  idx;
    logic        found;
    logic        pin_ok;
    logic        locked;
    logic        auth;
    logic [31:0] cur_bal;
    logic [32:0] dep_sum;
    logic [31:0] bal_new;
    logic        bal_we;
    logic        pin_we;
    logic [31:0] res_bal;
    logic        res_ok;

    logic [31:0] balance_p0;
    logic        success_p0;
    logic        vld_p0;

    // Unsigned add with the carry kept so overflow can be rejected instead of wrapping.
    function automatic logic [32:0] add_carry(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign found   = (32'(bus.acc_num) < 32'(NUM_ACCOUNTS));
    assign idx     = found ? bus.acc_num : 4'd0;
    assign pin_ok  = (pin_tab[idx] == bus.pin);
    assign auth    = found && pin_ok && !locked;
    assign cur_bal = bal_tab[idx];
    assign dep_sum = add_carry(cur_bal, bus.amount);

    assign bus.acc_index = idx;
    assign bus.acc_found = found;
    assign bus.acc_auth  = auth;
    assign bus.balance   = balance_p0;
    assign bus.success   = success_p0;
    assign bus.done      = vld_p0;

`ifdef ATM_LOCKOUT_EN
    logic [1:0] fail_cnt [NUM_ACCOUNTS];
    logic       lock     [NUM_ACCOUNTS];

    assign locked = lock[idx];

    // A wrong PIN on a real account counts toward lockout; a successful command forgives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                fail_cnt[i] <= 2'd0;
                lock[i]     <= 1'b0;
            end
        end else if (bus.op_valid && found) begin
            if (!pin_ok) begin
                if (fail_cnt[idx] == 2'd2)
                    lock[idx] <= 1'b1;
                if (fail_cnt[idx] != 2'd3)
                    fail_cnt[idx] <= fail_cnt[idx] + 2'd1;
            end else if (res_ok) begin
                fail_cnt[idx] <= 2'd0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        res_bal = auth ? cur_bal : 32'd0;
        res_ok  = 1'b0;
        bal_new = cur_bal;
        bal_we  = 1'b0;
        pin_we  = 1'b0;
        if (auth) begin
            case (bus.operation)
                OP_BALANCE: res_ok = 1'b1;
                OP_WITHDRAW: begin
                    if (bus.amount <= cur_bal) begin
                        bal_new = cur_bal - bus.amount;
                        bal_we  = 1'b1;
                        res_bal = bal_new;
                        res_ok  = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    if (!dep_sum[32]) begin
                        bal_new = dep_sum[31:0];
                        bal_we  = 1'b1;
                        res_bal = bal_new;
                        res_ok  = 1'b1;
                    end
                end
                OP_CHANGE_PIN: begin
                    pin_we = 1'b1;
                    res_ok = 1'b1;
                end
                default: res_ok = 1'b0;
            endcase
        end
    end

    // Stage p0: table writes and registered result, visible the cycle after the command.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                pin_tab[i] <= PIN_INIT_BASE + 16'(i);
                bal_tab[i] <= BAL_INIT;
            end
            balance_p0 <= 32'd0;
            success_p0 <= 1'b0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= bus.op_valid;
            if (bus.op_valid) begin
                balance_p0 <= res_bal;
                success_p0 <= res_ok;
                if (bal_we)
                    bal_tab[idx] <= bal_new;
                if (pin_we)
                    pin_tab[idx] <= bus.newPin;
            end
        end
    end
endmodule

// File: tb/tb_atm_account_engine.sv
// Self-checking bench for atm_account_engine: expected results queued at issue, compared on done.
module tb_atm_account_engine;
    localparam logic [2:0] OP_BAL = 3'd3;
    localparam logic [2:0] OP_WD  = 3'd4;
    localparam logic [2:0] OP_DEP = 3'd5;
    localparam logic [2:0] OP_CP  = 3'd6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [32:0] exp_q [$];
    logic [32:0] exp_item;

    atm_account_engine_if bus ();

    atm_account_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Result monitor: every done must match the oldest queued expectation, and no done may go missing.
    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=%b required 0", bus.done);
            end else begin
                exp_item = exp_q.pop_front();
                if (bus.balance !== exp_item[32:1] || bus.success !== exp_item[0]) begin
                    errors++;
                    $display("FAIL result: balance=%0d success=%b required balance=%0d success=%b",
                             bus.balance, bus.success, exp_item[32:1], exp_item[0]);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_done: done=%b required 1", bus.done);
            exp_q.delete();
        end
    end

    task automatic issue(input logic [3:0] a, input logic [15:0] p, input logic [2:0] op,
                         input logic [31:0] amt, input logic [15:0] np,
                         input logic ef, input logic ea, input logic [31:0] eb, input logic es);
        @(negedge clk);
        bus.acc_num   = a;
        bus.pin       = p;
        bus.operation = op;
        bus.amount    = amt;
        bus.newPin    = np;
        bus.op_valid  = 1'b1;
        #1;
        checks++;
        if (bus.acc_found !== ef || bus.acc_auth !== ea) begin
            errors++;
            $display("FAIL lookup acc=%0d pin=%0d: found=%b auth=%b required found=%b auth=%b",
                     a, p, bus.acc_found, bus.acc_auth, ef, ea);
        end
        exp_q.push_back({eb, es});
    endtask

    task automatic idle();
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.acc_num   = 4'd0;
        bus.pin       = 16'd1000;
        bus.newPin    = 16'd0;
        bus.amount    = 32'd500;
        bus.operation = OP_WD;
        bus.op_valid  = 1'b1;
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        bus.op_valid = 1'b0;
        #1;
        checks++;
        if (bus.balance !== 32'd0 || bus.success !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: balance=%0d success=%b done=%b required 0 0 0",
                     bus.balance, bus.success, bus.done);
        end
    endtask

    task automatic test_balance();
        issue(4'd2, 16'd1002, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
        idle();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.balance !== 32'd1000 || bus.success !== 1'b1) begin
            errors++;
            $display("FAIL hold: done=%b balance=%0d success=%b required 0 1000 1",
                     bus.done, bus.balance, bus.success);
        end
        checks++;
        if (bus.acc_index !== 4'd2) begin
            errors++;
            $display("FAIL index_found: acc_index=%0d required 2", bus.acc_index);
        end
    endtask

    task automatic test_withdraw();
        issue(4'd2, 16'd1002, OP_WD,  32'd300, 16'd0, 1'b1, 1'b1, 32'd700, 1'b1);
        issue(4'd2, 16'd1002, OP_BAL, 32'd0,   16'd0, 1'b1, 1'b1, 32'd700, 1'b1);
        issue(4'd2, 16'd1002, OP_WD,  32'd701, 16'd0, 1'b1, 1'b1, 32'd700, 1'b0);
        issue(4'd0, 16'd1000, OP_WD,  32'd0,   16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
        issue(4'd6, 16'd1006, OP_WD,  32'd1000, 16'd0, 1'b1, 1'b1, 32'd0, 1'b1);
        idle();
    endtask

    task automatic test_deposit();
        issue(4'd5, 16'd1005, OP_DEP, 32'd250,        16'd0, 1'b1, 1'b1, 32'd1250, 1'b1);
        issue(4'd5, 16'd1005, OP_DEP, 32'hFFFF_FFFF,  16'd0, 1'b1, 1'b1, 32'd1250, 1'b0);
        issue(4'd5, 16'd1005, OP_BAL, 32'd0,          16'd0, 1'b1, 1'b1, 32'd1250, 1'b1);
        issue(4'd6, 16'd1006, OP_DEP, 32'hFFFF_FFFF,  16'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        issue(4'd6, 16'd1006, OP_DEP, 32'd1,          16'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle();
    endtask

    task automatic test_change_pin();
        issue(4'd3, 16'd1003, OP_CP,  32'd0, 16'd4321, 1'b1, 1'b1, 32'd1000, 1'b1);
        issue(4'd3, 16'd1003, OP_BAL, 32'd0, 16'd0,    1'b1, 1'b0, 32'd0,    1'b0);
        issue(4'd3, 16'd4321, OP_BAL, 32'd0, 16'd0,    1'b1, 1'b1, 32'd1000, 1'b1);
        issue(4'd4, 16'd1004, OP_CP,  32'd0, 16'd1004, 1'b1, 1'b1, 32'd1000, 1'b1);
        issue(4'd4, 16'd1004, OP_BAL, 32'd0, 16'd0,    1'b1, 1'b1, 32'd1000, 1'b1);
        idle();
    endtask

    task automatic test_illegal();
        issue(4'd12, 16'd1012, OP_BAL, 32'd0, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checks++;
        if (bus.acc_index !== 4'd0) begin
            errors++;
            $display("FAIL index_not_found: acc_index=%0d required 0", bus.acc_index);
        end
        issue(4'd0, 16'd1000, 3'd7,   32'd5, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b0);
        issue(4'd0, 16'd1000, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
        idle();
    endtask

    task automatic test_lockout();
        for (int i = 0; i < 3; i++)
            issue(4'd1, 16'd9999, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b0, 32'd0, 1'b0);
`ifdef ATM_LOCKOUT_EN
        issue(4'd1, 16'd1001, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b0, 32'd0, 1'b0);
`else
        issue(4'd1, 16'd1001, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
`endif
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(4'd1, 16'd1001, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
        issue(4'd2, 16'd1002, OP_BAL, 32'd0, 16'd0, 1'b1, 1'b1, 32'd1000, 1'b1);
        idle();
    endtask

    initial begin
        test_reset();
        test_balance();
        test_withdraw();
        test_deposit();
        test_change_pin();
        test_illegal();
        test_lockout();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
